sd_init_sequencer: RTL and testbench

SD_INIT_SEQUENCER -- requirements
Module: sd_init_sequencer

---
 rtl/sd_init_sequencer.sv | 130 +++++++++++++
 tb/tb_sd_init_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer: runs the SD identification flow CMD0, CMD8, CMD55/ACMD41, CMD2, CMD3, CMD7
// over a send/get command engine and captures CCS, CID and RCA.
module sd_init_sequencer #(
  parameter int POWERUP_CYCLES = 80,
  parameter int RESP_TIMEOUT   = 1024,
  parameter int ACMD41_RETRIES = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Init_Start,
  output logic         Send_CMD_En,
  output logic         Get_CMD_En,
  input  logic         Send_CMD_Complite,
  input  logic         Get_CMD_Complite,
  output logic [5:0]   CMD_ID,
  output logic [7:0]   Arg1,
  output logic [7:0]   Arg2,
  output logic [7:0]   Arg3,
  output logic [7:0]   Arg4,
  input  logic [47:0]  Responce_R1_R3,
  input  logic [135:0] Responce_R2,
  output logic         Init_Busy,
  output logic         Init_Done,
  output logic         Init_Error,
  output logic [2:0]   Error_Code,
  output logic [15:0]  RCA,
  output logic         CCS,
  output logic [119:0] CID
);
  localparam int CMAX = (POWERUP_CYCLES > RESP_TIMEOUT) ? POWERUP_CYCLES : RESP_TIMEOUT;
  localparam int CW = $clog2(CMAX + 9);
  localparam int RW = $clog2(ACMD41_RETRIES + 1);
  typedef enum logic [2:0] {IDLE, POWERUP, SEND, GET, GAP, DONE, ERROR} state_t;
  typedef enum logic [2:0] {S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD2, S_CMD3, S_CMD7} step_t;
  state_t state, state_nxt;
  step_t step, step_nxt;
  logic phase, tmo, v2, eval, timeout, unused_rsp;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retries;
  logic [2:0] err, err_nxt;
  logic [15:0] rsp;
  logic [7:0] echo;
  logic [31:0] arg;
  // phase: in SEND, 0 = argument setup cycle, 1 = request raised; in GET, 0 = waiting, 1 = evaluate
  assign eval = state == GET && phase;
  assign timeout = state == GET && !phase && !Get_CMD_Complite && cnt == CW'(RESP_TIMEOUT - 1);
  assign unused_rsp = ^{Responce_R1_R3[47:40], Responce_R1_R3[23:16], Responce_R1_R3[7:0],
                        Responce_R2[135:128], Responce_R2[7:0]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      step <= S_CMD0;
    end else begin
      state <= state_nxt;
      step <= step_nxt;
    end
  always_comb begin
    state_nxt = state;
    step_nxt = step;
    err_nxt = err;
    case (state)
      IDLE: if (Init_Start) state_nxt = POWERUP;
      POWERUP: if (cnt == CW'(POWERUP_CYCLES - 1)) begin state_nxt = SEND; step_nxt = S_CMD0; end
      SEND: if (phase && Send_CMD_Complite) state_nxt = (step == S_CMD0) ? GAP : GET;
      GAP: if (cnt == CW'(7)) begin state_nxt = SEND; step_nxt = S_CMD8; end
      GET: if (phase) begin
        state_nxt = SEND;
        // a silent CMD8 marks a v1 card and is not an error
        if (tmo && step != S_CMD8) begin state_nxt = ERROR; err_nxt = 3'd3; end
        else case (step)
          S_CMD8: if (!tmo && echo != 8'hAA) begin state_nxt = ERROR; err_nxt = 3'd4; end
                  else step_nxt = S_CMD55;
          S_CMD55: step_nxt = S_ACMD41;
          S_ACMD41: if (rsp[15]) step_nxt = S_CMD2;
                    else if (retries + RW'(1) == RW'(ACMD41_RETRIES)) begin state_nxt = ERROR; err_nxt = 3'd2; end
                    else step_nxt = S_CMD55;
          S_CMD2: step_nxt = S_CMD3;
          S_CMD3: step_nxt = S_CMD7;
          default: state_nxt = DONE;
        endcase
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      phase <= 1'b0;
      cnt <= '0;
      retries <= '0;
      err <= '0;
      tmo <= 1'b0;
      rsp <= '0;
      echo <= '0;
      v2 <= 1'b0;
      CCS <= 1'b0;
      RCA <= '0;
      CID <= '0;
    end else begin
      phase <= state_nxt == state && (state == SEND || (state == GET && (phase || Get_CMD_Complite || timeout)));
      cnt <= (state_nxt != state) ? '0 : (state == POWERUP || state == GAP || state == GET) ? cnt + CW'(1) : cnt;
      err <= err_nxt;
      if (state == IDLE && state_nxt == POWERUP) retries <= '0;
      if (state == GET && !phase) tmo <= timeout;
      if (state == GET && !phase && Get_CMD_Complite) begin
        rsp <= Responce_R1_R3[39:24];
        echo <= Responce_R1_R3[15:8];
        if (step == S_CMD2) CID <= Responce_R2[127:8];
      end
      if (eval && step == S_CMD8) v2 <= !tmo;
      if (eval && !tmo && step == S_ACMD41) begin
        if (rsp[15]) CCS <= rsp[14];
        else retries <= retries + RW'(1);
      end
      if (eval && !tmo && step == S_CMD3) RCA <= rsp;
    end
  always_comb begin
    arg = (step == S_CMD8) ? 32'h0000_01AA :
          (step == S_ACMD41) ? (v2 ? 32'h40FF_8000 : 32'h00FF_8000) :
          (step == S_CMD7) ? {RCA, 16'h0000} : 32'h0;
    {Arg1, Arg2, Arg3, Arg4} = arg;
    CMD_ID = (step == S_CMD8) ? 6'd8 : (step == S_CMD55) ? 6'd55 : (step == S_ACMD41) ? 6'd41 :
             (step == S_CMD2) ? 6'd2 : (step == S_CMD3) ? 6'd3 : (step == S_CMD7) ? 6'd7 : 6'd0;
    Send_CMD_En = state == SEND && phase;
    Get_CMD_En = state == GET && !phase;
    Init_Busy = state != IDLE && state != DONE && state != ERROR;
    Init_Done = state == DONE;
    Init_Error = state == ERROR;
    Error_Code = (state == ERROR) ? err : 3'd0;
  end
endmodule

// File: tb/tb_sd_init_sequencer.sv
// tb_sd_init_sequencer: randomized card responder checked against a command-list model of the init flow.
module tb_sd_init_sequencer;
  localparam int PU = 80, TO = 1024, RT = 3;
  logic clk, rst, Init_Start;
  logic Send_CMD_En, Get_CMD_En, Send_CMD_Complite, Get_CMD_Complite;
  logic [5:0] CMD_ID;
  logic [7:0] Arg1, Arg2, Arg3, Arg4;
  logic [47:0] Responce_R1_R3;
  logic [135:0] Responce_R2;
  logic Init_Busy, Init_Done, Init_Error, CCS;
  logic [2:0] Error_Code;
  logic [15:0] RCA;
  logic [119:0] CID;
  int checks = 0, fails = 0;
  logic [5:0] hang_cmd, last_cmd;
  logic [7:0] echo;
  int busy_n, a41_cnt;
  logic card_ccs;
  logic [15:0] card_rca;
  logic [119:0] card_cid;
  logic [37:0] sent_q[$], exp_q[$];
  int cyc = 0, busy_rise = 0, first_send = 0, cmd0_last = 0, cmd8_start = 0, get8_cnt = 0, overlap = 0;
  int s_dly = 0, g_dly = 0;
  bit busy_prev = 0, id8_seen = 0, s_seen = 0, g_seen = 0;
  logic exp_done, exp_err, exp_ccs;
  logic [2:0] exp_code;
  logic [15:0] exp_rca;
  logic [119:0] exp_cid;

  sd_init_sequencer #(.POWERUP_CYCLES(PU), .RESP_TIMEOUT(TO), .ACMD41_RETRIES(RT)) dut (
    .clk(clk), .rst(rst), .Init_Start(Init_Start),
    .Send_CMD_En(Send_CMD_En), .Get_CMD_En(Get_CMD_En),
    .Send_CMD_Complite(Send_CMD_Complite), .Get_CMD_Complite(Get_CMD_Complite),
    .CMD_ID(CMD_ID), .Arg1(Arg1), .Arg2(Arg2), .Arg3(Arg3), .Arg4(Arg4),
    .Responce_R1_R3(Responce_R1_R3), .Responce_R2(Responce_R2),
    .Init_Busy(Init_Busy), .Init_Done(Init_Done), .Init_Error(Init_Error),
    .Error_Code(Error_Code), .RCA(RCA), .CCS(CCS), .CID(CID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp_v);
    end
  endtask

  // card side: answers each request with a random latency; the hung command never answers its get
  task automatic respond();
    Responce_R1_R3 = {16'($urandom()), 32'($urandom())};
    Responce_R2 = {8'($urandom()), card_cid, 8'($urandom())};
    case (last_cmd)
      6'd8: Responce_R1_R3[15:8] = echo;
      6'd41: begin
        Responce_R1_R3[39] = (a41_cnt == busy_n);
        if (a41_cnt == busy_n) Responce_R1_R3[38] = card_ccs;
        a41_cnt++;
      end
      6'd3: Responce_R1_R3[39:24] = card_rca;
      default: ;
    endcase
  endtask

  initial begin
    Send_CMD_Complite = 1'b0;
    Get_CMD_Complite = 1'b0;
    Responce_R1_R3 = '0;
    Responce_R2 = '0;
    last_cmd = 6'd0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (Send_CMD_En && Get_CMD_En) overlap++;
      if (Init_Busy && !busy_prev) busy_rise = cyc;
      busy_prev = Init_Busy;
      if (CMD_ID == 6'd8 && !id8_seen) begin id8_seen = 1; cmd8_start = cyc; end
      if (Send_CMD_En) begin
        if (!s_seen) begin
          s_seen = 1;
          last_cmd = CMD_ID;
          s_dly = $urandom_range(0, 3);
          sent_q.push_back({CMD_ID, Arg1, Arg2, Arg3, Arg4});
          if (CMD_ID == 6'd0) first_send = cyc;
        end else if (s_dly != 0) s_dly--;
        if (CMD_ID == 6'd0) cmd0_last = cyc;
        Send_CMD_Complite = (s_dly == 0);
      end else begin
        s_seen = 0;
        Send_CMD_Complite = 1'b0;
      end
      if (Get_CMD_En) begin
        if (CMD_ID == 6'd8) get8_cnt++;
        if (!g_seen) begin g_seen = 1; g_dly = $urandom_range(0, 4); end
        else if (g_dly != 0) g_dly--;
        if (g_dly == 0 && last_cmd != hang_cmd && !Get_CMD_Complite) begin
          respond();
          Get_CMD_Complite = 1'b1;
        end
      end else begin
        g_seen = 0;
        Get_CMD_Complite = 1'b0;
      end
    end
  end

  // expected command list and final status, derived from the card behaviour
  task automatic build_model();
    logic v2, ready;
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_code = 0; exp_ccs = 0; exp_rca = 0; exp_cid = 0; ready = 0;
    exp_q.push_back({6'd0, 32'h0});
    exp_q.push_back({6'd8, 32'h0000_01AA});
    if (hang_cmd != 6'd8 && echo != 8'hAA) begin exp_err = 1; exp_code = 4; return; end
    v2 = (hang_cmd != 6'd8);
    for (int i = 0; i < RT; i++) begin
      exp_q.push_back({6'd55, 32'h0});
      if (hang_cmd == 6'd55) begin exp_err = 1; exp_code = 3; return; end
      exp_q.push_back({6'd41, v2 ? 32'h40FF_8000 : 32'h00FF_8000});
      if (hang_cmd == 6'd41) begin exp_err = 1; exp_code = 3; return; end
      if (i == busy_n) begin ready = 1; break; end
    end
    if (!ready) begin exp_err = 1; exp_code = 2; return; end
    exp_ccs = card_ccs;
    exp_q.push_back({6'd2, 32'h0});
    if (hang_cmd == 6'd2) begin exp_err = 1; exp_code = 3; return; end
    exp_cid = card_cid;
    exp_q.push_back({6'd3, 32'h0});
    if (hang_cmd == 6'd3) begin exp_err = 1; exp_code = 3; return; end
    exp_rca = card_rca;
    exp_q.push_back({6'd7, card_rca, 16'h0000});
    if (hang_cmd == 6'd7) begin exp_err = 1; exp_code = 3; return; end
    exp_done = 1;
  endtask

  task automatic clear_bench();
    sent_q.delete();
    a41_cnt = 0; id8_seen = 0; get8_cnt = 0;
    cmd0_last = 0; cmd8_start = 0; first_send = 0; busy_rise = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    Init_Start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    clear_bench();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 Init_Start = 1'b1;
    @(posedge clk); #1 Init_Start = 1'b0;
  endtask

  task automatic rand_card();
    logic [5:0] hangs [7];
    hangs = '{6'd63, 6'd8, 6'd55, 6'd41, 6'd2, 6'd3, 6'd7};
    hang_cmd = ($urandom_range(0, 2) == 0) ? hangs[$urandom_range(1, 6)] : 6'd63;
    echo = ($urandom_range(0, 3) != 0) ? 8'hAA : 8'($urandom_range(0, 169));
    busy_n = $urandom_range(0, RT);
    card_ccs = 1'($urandom_range(0, 1));
    card_rca = 16'($urandom());
    card_cid = {24'($urandom()), 32'($urandom()), 32'($urandom()), 32'($urandom())};
  endtask

  task automatic run_scenario(input string tag);
    int n, sz;
    logic [37:0] o;
    build_model();
    pulse_start();
    n = 0;
    while (!(Init_Done || Init_Error) && n < 4000) begin
      @(posedge clk); #1;
      n++;
      Init_Start = (n == 150);
    end
    Init_Start = 1'b0;
    chk({tag, "_finished"}, 128'(n < 4000), 128'(1));
    chk({tag, "_done"}, 128'(Init_Done), 128'(exp_done));
    chk({tag, "_error"}, 128'(Init_Error), 128'(exp_err));
    chk({tag, "_code"}, 128'(Error_Code), 128'(exp_code));
    chk({tag, "_busy"}, 128'(Init_Busy), 128'(0));
    chk({tag, "_ccs"}, 128'(CCS), 128'(exp_ccs));
    chk({tag, "_rca"}, 128'(RCA), 128'(exp_rca));
    chk({tag, "_cid"}, 128'(CID), 128'(exp_cid));
    chk({tag, "_ncmds"}, 128'(sent_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (i < sent_q.size()) ? sent_q[i] : '1;
      chk($sformatf("%s_cmd%0d", tag, i), 128'(o), 128'(exp_q[i]));
    end
    sz = sent_q.size();
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_sticky_done"}, 128'(Init_Done), 128'(exp_done));
    chk({tag, "_sticky_error"}, 128'(Init_Error), 128'(exp_err));
    chk({tag, "_no_resend"}, 128'(sent_q.size()), 128'(sz));
  endtask

  initial begin
    int n, a41s;
    rst = 1'b0;
    Init_Start = 1'b0;
    hang_cmd = 6'd63; echo = 8'hAA; busy_n = 0; card_ccs = 0; card_rca = 0; card_cid = '0; a41_cnt = 0;
    #23;
    chk("rst_send_en", 128'(Send_CMD_En), 128'(0));
    chk("rst_get_en", 128'(Get_CMD_En), 128'(0));
    chk("rst_status", 128'({Init_Busy, Init_Done, Init_Error}), 128'(0));
    chk("rst_regs", 128'({Error_Code, RCA, CCS}), 128'(0));
    chk("rst_cid", 128'(CID), 128'(0));
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    chk("idle_after_release", 128'({Init_Busy, Send_CMD_En, sent_q.size() != 0}), 128'(0));

    // v2 card, two busy ACMD41 replies, high capacity
    hang_cmd = 6'd63; echo = 8'hAA; busy_n = 2; card_ccs = 1; card_rca = 16'h1234;
    card_cid = {24'hABCDEF, 32'h01234567, 32'h89ABCDEF, 32'h55AA33CC};
    run_scenario("v2");
    chk("v2_cmd7_args", 128'({Arg1, Arg2, Arg3, Arg4}), 128'(32'h1234_0000));
    chk("powerup_len", 128'(first_send - busy_rise), 128'(PU + 1));
    chk("cmd0_gap", 128'(cmd8_start - cmd0_last), 128'(8 + 1));

    // v1 card: CMD8 never answered
    do_reset();
    hang_cmd = 6'd8; busy_n = 1; card_ccs = 0; card_rca = 16'h0BEE;
    run_scenario("v1");
    chk("v1_cmd8_get_cycles", 128'(get8_cnt), 128'(TO));

    do_reset();
    hang_cmd = 6'd63; echo = 8'h55; busy_n = 0;
    run_scenario("bad_echo");

    do_reset();
    echo = 8'hAA; busy_n = RT; card_ccs = 1;
    run_scenario("never_ready");
    a41s = 0;
    foreach (sent_q[i]) if (sent_q[i][37:32] == 6'd41) a41s++;
    chk("never_ready_acmd41_sends", 128'(a41s), 128'(RT));

    do_reset();
    hang_cmd = 6'd3; busy_n = 0; card_ccs = 1; card_rca = 16'hCAFE;
    run_scenario("cmd3_timeout");

    for (int k = 0; k < 6; k++) begin
      do_reset();
      rand_card();
      run_scenario($sformatf("rand%0d", k));
    end

    // reset while CMD2 is being sent, then a full restart
    do_reset();
    hang_cmd = 6'd63; echo = 8'hAA; busy_n = 1; card_ccs = 1; card_rca = 16'h4321;
    card_cid = {24'h123456, 32'hDEADBEEF, 32'h0F0F0F0F, 32'h13579BDF};
    pulse_start();
    n = 0;
    while (!(Send_CMD_En && CMD_ID == 6'd2) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd2_reached", 128'(n < 4000), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_send_en", 128'(Send_CMD_En), 128'(0));
    chk("mid_rst_get_en", 128'(Get_CMD_En), 128'(0));
    chk("mid_rst_busy", 128'(Init_Busy), 128'(0));
    chk("mid_rst_ccs", 128'(CCS), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", 128'({Init_Busy, Init_Done, Init_Error, Send_CMD_En}), 128'(0));
    clear_bench();
    run_scenario("restart");
    chk("restart_powerup_len", 128'(first_send - busy_rise), 128'(PU + 1));

    chk("en_overlap", 128'(overlap), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
